// File: rtl/ysyx_22050058_memarb.sv
// Shared memory-port arbiter between instruction fetch (IF) and load/store (MEM).
// One outstanding bus transaction at a time; MEM has priority except that a
// waiting fetch is forced through after MEM_BURST_MAX consecutive MEM grants.
module ysyx_22050058_memarb #(
  parameter int MEM_BURST_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  // fetch side
  input  logic        if_req_i,
  input  logic [63:0] if_addr_i,
  input  logic        if_flush_i,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  // load/store side
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [63:0] mem_addr_i,
  input  logic [63:0] mem_wdata_i,
  input  logic [7:0]  mem_wmask_i,
  output logic        mem_rvalid_o,
  output logic [63:0] mem_rdata_o,
  // shared bus port
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [63:0] bus_addr_o,
  output logic [63:0] bus_wdata_o,
  output logic [7:0]  bus_wmask_o,
  input  logic        bus_ready_i,
  input  logic        bus_rvalid_i,
  input  logic [63:0] bus_rdata_i,
  // stall requests
  output logic        stall_ifreq_o,
  output logic        stall_memreq_o
);

  localparam int SW = $clog2(MEM_BURST_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;

  state_t        state_q, state_d;
  owner_t        owner_q, owner_d;
  logic [SW-1:0] mem_streak_q, mem_streak_d;
  logic          drop_q, drop_d;
  logic          we_q, we_d;
  logic [63:0]   addr_q, addr_d;
  logic [63:0]   wdata_q, wdata_d;
  logic [7:0]    wmask_q, wmask_d;

  logic          streak_full;
  logic          mem_win;
  logic          if_win;
  logic          resp_hit;
  logic          if_flush_own;

  // Arbitration: MEM first, unless the fetch has been starved long enough.
  assign streak_full  = (mem_streak_q == SW'(MEM_BURST_MAX));
  assign mem_win      = mem_req_i & ~(streak_full & if_req_i);
  assign if_win       = if_req_i & ~mem_win;
  assign resp_hit     = (state_q == S_RESP) & bus_rvalid_i;
  assign if_flush_own = if_flush_i & (owner_q == OWN_IF);

  // Next-state, owner, latched bus fields, streak counter and drop flag.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    mem_streak_d = mem_streak_q;
    drop_d       = drop_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    unique case (state_q)
      S_IDLE: begin
        drop_d = 1'b0;
        if (mem_win) begin
          state_d = S_REQ;
          owner_d = OWN_MEM;
          we_d    = mem_we_i;
          addr_d  = mem_addr_i;
          wdata_d = mem_wdata_i;
          wmask_d = mem_wmask_i;
          if (!if_req_i) begin
            mem_streak_d = '0;
          end else if (!streak_full) begin
            mem_streak_d = mem_streak_q + SW'(1);
          end
        end else if (if_win) begin
          state_d      = S_REQ;
          owner_d      = OWN_IF;
          we_d         = 1'b0;
          addr_d       = if_addr_i;
          wdata_d      = '0;
          wmask_d      = 8'h00;
          mem_streak_d = '0;
        end
      end
      S_REQ: begin
        if (if_flush_own) drop_d = 1'b1;
        if (bus_ready_i)  state_d = S_RESP;
      end
      S_RESP: begin
        if (if_flush_own) drop_d = 1'b1;
        if (bus_rvalid_i) begin
          state_d = S_IDLE;
          drop_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        drop_d  = 1'b0;
      end
    endcase
  end

  // State and latched transaction registers; reset abandons any transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_IF;
      mem_streak_q <= '0;
      drop_q       <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      mem_streak_q <= mem_streak_d;
      drop_q       <= drop_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
    end
  end

  // Bus request side: fields come straight from the latched registers.
  assign bus_req_o   = (state_q == S_REQ);
  assign bus_we_o    = we_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign bus_wmask_o = wmask_q;

  // Response delivery in the same cycle as bus_rvalid_i; a flush arriving in
  // that very cycle still suppresses the fetch pulse.
  always_comb begin
    if_rvalid_o  = 1'b0;
    if_rdata_o   = '0;
    mem_rvalid_o = 1'b0;
    mem_rdata_o  = '0;
    if (resp_hit) begin
      if (owner_q == OWN_MEM) begin
        mem_rvalid_o = 1'b1;
        mem_rdata_o  = bus_rdata_i;
      end else if (!drop_q && !if_flush_i) begin
        if_rvalid_o = 1'b1;
        if_rdata_o  = addr_q[2] ? bus_rdata_i[63:32] : bus_rdata_i[31:0];
      end
    end
  end

  assign stall_ifreq_o  = if_req_i & ~if_rvalid_o;
  assign stall_memreq_o = mem_req_i & ~mem_rvalid_o;

endmodule

// File: tb/tb_ysyx_22050058_memarb.sv
// Directed testbench for ysyx_22050058_memarb with hand-computed expectations.
module tb_ysyx_22050058_memarb;

  logic        clk;
  logic        rst;
  logic        if_req_i;
  logic [63:0] if_addr_i;
  logic        if_flush_i;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [63:0] mem_addr_i;
  logic [63:0] mem_wdata_i;
  logic [7:0]  mem_wmask_i;
  logic        mem_rvalid_o;
  logic [63:0] mem_rdata_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [63:0] bus_addr_o;
  logic [63:0] bus_wdata_o;
  logic [7:0]  bus_wmask_o;
  logic        bus_ready_i;
  logic        bus_rvalid_i;
  logic [63:0] bus_rdata_i;
  logic        stall_ifreq_o;
  logic        stall_memreq_o;

  int n_chk;
  int n_pass;

  ysyx_22050058_memarb #(.MEM_BURST_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_wmask_i(mem_wmask_i),
    .mem_rvalid_o(mem_rvalid_o), .mem_rdata_o(mem_rdata_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_wmask_o(bus_wmask_o),
    .bus_ready_i(bus_ready_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
    .stall_ifreq_o(stall_ifreq_o), .stall_memreq_o(stall_memreq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Move to the middle of the next clock cycle.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Called mid-cycle while in REQ: ready now, response next cycle.
  task automatic serve(input string tag, input logic [63:0] rd, input logic exp_if,
                       input logic exp_mem, input logic [31:0] exp_ifd);
    bus_ready_i = 1'b1;
    tick();
    bus_ready_i  = 1'b0;
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = rd;
    #1;
    chk({tag, ".bus_req_resp"}, 64'(bus_req_o), 64'd0);
    chk({tag, ".if_rvalid"},    64'(if_rvalid_o), 64'(exp_if));
    chk({tag, ".if_rdata"},     64'(if_rdata_o), exp_if ? 64'(exp_ifd) : 64'd0);
    chk({tag, ".mem_rvalid"},   64'(mem_rvalid_o), 64'(exp_mem));
    chk({tag, ".mem_rdata"},    mem_rdata_o, exp_mem ? rd : 64'd0);
    chk({tag, ".stall_if"},     64'(stall_ifreq_o), 64'(if_req_i & ~exp_if));
    chk({tag, ".stall_mem"},    64'(stall_memreq_o), 64'(mem_req_i & ~exp_mem));
    tick();
    bus_rvalid_i = 1'b0;
    bus_rdata_i  = '0;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    if_req_i = 0; if_addr_i = '0; if_flush_i = 0;
    mem_req_i = 0; mem_we_i = 0; mem_addr_i = '0; mem_wdata_i = '0; mem_wmask_i = '0;
    bus_ready_i = 0; bus_rvalid_i = 0; bus_rdata_i = '0;

    // Reset state
    #1;
    chk("rst.bus_req", 64'(bus_req_o), 64'd0);
    chk("rst.bus_addr", bus_addr_o, 64'd0);
    chk("rst.bus_we", 64'(bus_we_o), 64'd0);
    chk("rst.if_rvalid", 64'(if_rvalid_o), 64'd0);
    chk("rst.mem_rvalid", 64'(mem_rvalid_o), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Single fetch, minimum latency, upper word selected by addr[2]
    if_req_i = 1; if_addr_i = 64'h8000_0004;
    #1;
    chk("f1.idle_bus_req", 64'(bus_req_o), 64'd0);
    chk("f1.stall_if", 64'(stall_ifreq_o), 64'd1);
    tick();
    chk("f1.bus_req", 64'(bus_req_o), 64'd1);
    chk("f1.bus_addr", bus_addr_o, 64'h8000_0004);
    chk("f1.bus_we", 64'(bus_we_o), 64'd0);
    chk("f1.bus_wmask", 64'(bus_wmask_o), 64'd0);
    serve("f1", 64'h1111_2222_3333_4444, 1'b1, 1'b0, 32'h1111_2222);
    if_req_i = 0;
    #1;
    chk("f1.after_if_rdata", 64'(if_rdata_o), 64'd0);
    tick();
    chk("f1.idle", 64'(bus_req_o), 64'd0);

    // IF and MEM together: MEM first, IF only after mem_rvalid_o
    if_req_i = 1; if_addr_i = 64'h8000_0000;
    mem_req_i = 1; mem_we_i = 0; mem_addr_i = 64'h1000; mem_wmask_i = 8'hFF;
    tick();
    chk("pr.bus_addr_mem", bus_addr_o, 64'h1000);
    serve("pr.mem", 64'hAAAA_BBBB_CCCC_DDDD, 1'b0, 1'b1, 32'h0);
    mem_req_i = 0;
    #1;
    chk("pr.no_if_yet", 64'(bus_req_o), 64'd0);
    tick();
    chk("pr.bus_addr_if", bus_addr_o, 64'h8000_0000);
    chk("pr.if_wmask", 64'(bus_wmask_o), 64'd0);
    serve("pr.if", 64'h0102_0304_0506_0708, 1'b1, 1'b0, 32'h0506_0708);
    if_req_i = 0;
    tick();

    // IF held, MEM back-to-back: four MEM grants then IF
    if_req_i = 1; if_addr_i = 64'h8000_0010;
    mem_req_i = 1; mem_addr_i = 64'h2000;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k < 4) begin
        chk($sformatf("bs.addr%0d", k), bus_addr_o, 64'h2000);
        chk($sformatf("bs.streak%0d", k), 64'(dut.mem_streak_q), 64'(k + 1));
        serve($sformatf("bs.m%0d", k), 64'(k) + 64'h100, 1'b0, 1'b1, 32'h0);
      end else begin
        chk("bs.addr_if", bus_addr_o, 64'h8000_0010);
        chk("bs.streak_clr", 64'(dut.mem_streak_q), 64'd0);
        serve("bs.if", 64'h9999_8888_7777_6666, 1'b1, 1'b0, 32'h7777_6666);
        if_req_i = 0; mem_req_i = 0;
      end
    end
    tick();

    // Flush during RESP drops the fetch; next fetch served normally
    if_req_i = 1; if_addr_i = 64'h8000_0008;
    tick();
    bus_ready_i = 1;
    tick();
    bus_ready_i = 0; if_flush_i = 1;
    tick();
    if_flush_i = 0; if_addr_i = 64'h8000_0004;
    bus_rvalid_i = 1; bus_rdata_i = 64'h5555_6666_7777_8888;
    #1;
    chk("fl.if_rvalid", 64'(if_rvalid_o), 64'd0);
    chk("fl.if_rdata", 64'(if_rdata_o), 64'd0);
    tick();
    bus_rvalid_i = 0; bus_rdata_i = '0;
    #1;
    chk("fl.idle", 64'(bus_req_o), 64'd0);
    tick();
    chk("fl.next_addr", bus_addr_o, 64'h8000_0004);
    serve("fl.next", 64'h1111_2222_3333_4444, 1'b1, 1'b0, 32'h1111_2222);
    if_req_i = 0;
    tick();

    // Flush in the response cycle itself
    if_req_i = 1; if_addr_i = 64'h8000_000C;
    tick();
    bus_ready_i = 1;
    tick();
    bus_ready_i = 0; bus_rvalid_i = 1; if_flush_i = 1; bus_rdata_i = 64'hDEAD_0000_BEEF_0000;
    #1;
    chk("flr.if_rvalid", 64'(if_rvalid_o), 64'd0);
    tick();
    bus_rvalid_i = 0; if_flush_i = 0; if_req_i = 0; bus_rdata_i = '0;
    tick();

    // Store with slow ready: fields stable; flush with MEM owner is ignored
    mem_req_i = 1; mem_we_i = 1; mem_addr_i = 64'h3008;
    mem_wdata_i = 64'hDEAD_BEEF_CAFE_F00D; mem_wmask_i = 8'h0F;
    tick();
    for (int i = 0; i < 3; i++) begin
      if_flush_i = (i == 1);
      #1;
      chk($sformatf("st.req%0d", i), 64'(bus_req_o), 64'd1);
      chk($sformatf("st.we%0d", i), 64'(bus_we_o), 64'd1);
      chk($sformatf("st.addr%0d", i), bus_addr_o, 64'h3008);
      chk($sformatf("st.wdata%0d", i), bus_wdata_o, 64'hDEAD_BEEF_CAFE_F00D);
      chk($sformatf("st.wmask%0d", i), 64'(bus_wmask_o), 64'h0F);
      chk($sformatf("st.stall%0d", i), 64'(stall_memreq_o), 64'd1);
      tick();
    end
    if_flush_i = 0;
    serve("st.ack", 64'h0, 1'b0, 1'b1, 32'h0);
    mem_req_i = 0; mem_we_i = 0;
    tick();

    // Reset in RESP, then a stale response
    if_req_i = 1; if_addr_i = 64'h8000_0004;
    tick();
    bus_ready_i = 1;
    tick();
    bus_ready_i = 0;
    rst = 1;
    #1;
    chk("rr.bus_req", 64'(bus_req_o), 64'd0);
    chk("rr.bus_addr", bus_addr_o, 64'd0);
    tick();
    rst = 0;
    mem_req_i = 1;
    bus_rvalid_i = 1; bus_rdata_i = 64'h1234_5678_9ABC_DEF0;
    #1;
    chk("rr.if_rvalid", 64'(if_rvalid_o), 64'd0);
    chk("rr.mem_rvalid", 64'(mem_rvalid_o), 64'd0);
    chk("rr.if_rdata", 64'(if_rdata_o), 64'd0);
    chk("rr.mem_rdata", mem_rdata_o, 64'd0);
    chk("rr.stall_if", 64'(stall_ifreq_o), 64'd1);
    chk("rr.stall_mem", 64'(stall_memreq_o), 64'd1);
    if_req_i = 0; mem_req_i = 0; bus_rvalid_i = 0; bus_rdata_i = '0;
    tick();
    chk("rr.idle", 64'(bus_req_o), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
